bxu_front_seq: RTL and testbench

//  Sequential successor to the BXU combinational decoder. Accepts code words from fetch over valid/ack and issues

---
 rtl/bxu_pkg.sv | 51 +++++
 rtl/bxu_op_decode.sv | 29 ++
 rtl/bxu_front_seq.sv | 140 ++++++++++++++
 tb/tb_bxu_front_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bxu_pkg.sv
// Shared opcode, flag-encoding and state definitions for the BXU sequential front end.
package bxu_pkg;

  localparam logic [3:0] OPC_NOP   = 4'b0000;
  localparam logic [3:0] OPC_D_MOD = 4'b0010;
  localparam logic [3:0] OPC_D_SET = 4'b1010;
  localparam logic [3:0] OPC_S_MOD = 4'b0110;
  localparam logic [3:0] OPC_S_SET = 4'b1110;
  localparam logic [3:0] OPC_J_MOD = 4'b0001;
  localparam logic [3:0] OPC_J_SET = 4'b1001;
  localparam logic [3:0] OPC_JC_NZ = 4'b0101;
  localparam logic [3:0] OPC_JC_Z  = 4'b1101;
  localparam logic [3:0] OPC_IN    = 4'b1011;
  localparam logic [3:0] OPC_OUT   = 4'b0011;

  localparam logic [1:0] CADDR_NOP = 2'd0;
  localparam logic [1:0] CADDR_INC = 2'd1;
  localparam logic [1:0] CADDR_MOD = 2'd2;
  localparam logic [1:0] CADDR_SET = 2'd3;

  localparam logic [1:0] DADDR_NOP = 2'd0;
  localparam logic [1:0] DADDR_MOD = 2'd1;
  localparam logic [1:0] DADDR_SET = 2'd2;

  localparam logic [1:0] DATA_NOP = 2'd0;
  localparam logic [1:0] DATA_MOD = 2'd1;
  localparam logic [1:0] DATA_SET = 2'd2;
  localparam logic [1:0] DATA_GET = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REPEAT,
    ST_IN_WAIT,
    ST_OUT_WAIT
  } state_t;

  typedef struct packed {
    logic nop;
    logic j;
    logic jc;
    logic d;
    logic s;
    logic i;
    logic o;
  } op_cls_t;

  function automatic int arg_width(input int code_bitwidth);
    return code_bitwidth - 4;
  endfunction

endpackage

// File: rtl/bxu_op_decode.sv
// Combinational opcode classifier: code[3:0] -> one-hot op class plus mod/set and z/nz selects.
module bxu_op_decode
  import bxu_pkg::*;
(
  input  logic [3:0] opc,
  output op_cls_t    cls,
  output logic       sel_set,
  output logic       sel_z
);

  always_comb begin
    cls     = '0;
    sel_set = opc[3];
    sel_z   = opc[3];
    case (opc[2:0])
      3'b010:  cls.d = 1'b1;
      3'b110:  cls.s = 1'b1;
      3'b001:  cls.j = 1'b1;
      3'b101:  cls.jc = 1'b1;
      3'b011: begin
        if (opc[3]) cls.i = 1'b1;
        else        cls.o = 1'b1;
      end
      // 000 with bit3 set, 100 and 111 are illegal and fold into nop
      default: cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/bxu_front_seq.sv
// BXU front end: accepts code words over valid/ack and issues registered one-cycle op flags,
// with repeat-fused d/s ops, a data_wr->condition interlock and req/ack I/O waits.
module bxu_front_seq
  import bxu_pkg::*;
#(
  parameter int DATA_BITWIDTH = 8,
  parameter int CODE_BITWIDTH = 16,
  parameter int REP_BITWIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CODE_BITWIDTH-1:0]             code,
  input  logic                                 code_valid,
  output logic                                 code_ack,
  input  logic [DATA_BITWIDTH-1:0]             data,
  output logic                                 io_input_req,
  input  logic                                 io_input_ack,
  output logic                                 io_output_req,
  input  logic                                 io_output_ack,
  output logic [1:0]                           flag_op_caddr,
  output logic [1:0]                           flag_op_daddr,
  output logic [1:0]                           flag_op_data,
  output logic                                 flag_op_data_wr,
  output logic [arg_width(CODE_BITWIDTH)-1:0]  op_arg,
  output logic                                 busy
);

  localparam int AW = arg_width(CODE_BITWIDTH);

  op_cls_t                 cls;
  logic                    sel_set, sel_z;
  state_t                  state, state_nxt;
  logic [REP_BITWIDTH-1:0] cnt, cnt_nxt, rep_raw, rep_eff;
  logic                    rep_is_d, rep_is_d_nxt;
  logic [1:0]              caddr_nxt, daddr_nxt, data_nxt;
  logic                    wr_nxt;
  logic [AW-1:0]           arg_nxt;
  logic                    hazard, accept, taken, multi;

  bxu_op_decode u_dec (
    .opc     (code[3:0]),
    .cls     (cls),
    .sel_set (sel_set),
    .sel_z   (sel_z)
  );

  assign rep_raw  = code[4 +: REP_BITWIDTH];
  assign rep_eff  = (rep_raw == '0) ? REP_BITWIDTH'(1) : rep_raw;
  assign multi    = (cls.d | cls.s) & ~sel_set & (rep_eff > REP_BITWIDTH'(1));
  // The cell being written this cycle is not yet visible on data, so jc/o must wait one cycle.
  assign hazard   = flag_op_data_wr & (cls.jc | cls.o);
  assign accept   = (state == ST_IDLE) & code_valid & ~hazard;
  assign code_ack = accept;
  assign taken    = sel_z ? (data == '0) : (data != '0);

  assign busy          = (state != ST_IDLE);
  assign io_input_req  = (state == ST_IN_WAIT);
  assign io_output_req = (state == ST_OUT_WAIT);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rep_is_d_nxt = rep_is_d;
    caddr_nxt    = CADDR_NOP;
    daddr_nxt    = DADDR_NOP;
    data_nxt     = DATA_NOP;
    wr_nxt       = 1'b0;
    arg_nxt      = op_arg;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          arg_nxt = code[CODE_BITWIDTH-1:4];
          if (cls.nop | cls.d | cls.s) caddr_nxt = CADDR_INC;
          if (cls.j)  caddr_nxt = sel_set ? CADDR_SET : CADDR_MOD;
          if (cls.jc) caddr_nxt = taken ? CADDR_MOD : CADDR_INC;
          if (cls.d) begin
            data_nxt = sel_set ? DATA_SET : DATA_MOD;
            wr_nxt   = 1'b1;
          end
          if (cls.s) daddr_nxt = sel_set ? DADDR_SET : DADDR_MOD;
          if (multi) begin
            state_nxt    = ST_REPEAT;
            cnt_nxt      = rep_eff;
            rep_is_d_nxt = cls.d;
          end
          if (cls.i) state_nxt = ST_IN_WAIT;
          if (cls.o) state_nxt = ST_OUT_WAIT;
        end
      end
      ST_REPEAT: begin
        if (rep_is_d) begin
          data_nxt = DATA_MOD;
          wr_nxt   = 1'b1;
        end else begin
          daddr_nxt = DADDR_MOD;
        end
        cnt_nxt = cnt - REP_BITWIDTH'(1);
        if (cnt <= REP_BITWIDTH'(2)) state_nxt = ST_IDLE;
      end
      ST_IN_WAIT: begin
        if (io_input_ack) begin
          data_nxt  = DATA_GET;
          wr_nxt    = 1'b1;
          caddr_nxt = CADDR_INC;
          state_nxt = ST_IDLE;
        end
      end
      ST_OUT_WAIT: begin
        if (io_output_ack) begin
          caddr_nxt = CADDR_INC;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      rep_is_d        <= 1'b0;
      flag_op_caddr   <= CADDR_NOP;
      flag_op_daddr   <= DADDR_NOP;
      flag_op_data    <= DATA_NOP;
      flag_op_data_wr <= 1'b0;
      op_arg          <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      rep_is_d        <= rep_is_d_nxt;
      flag_op_caddr   <= caddr_nxt;
      flag_op_daddr   <= daddr_nxt;
      flag_op_data    <= data_nxt;
      flag_op_data_wr <= wr_nxt;
      op_arg          <= arg_nxt;
    end
  end

endmodule

// File: tb/tb_bxu_front_seq.sv
// Self-checking bench for bxu_front_seq: expected flag cycles are queued at issue and matched per cycle.
module tb_bxu_front_seq;
  import bxu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] code;
  logic        code_valid;
  logic        code_ack;
  logic [7:0]  data;
  logic        io_input_req, io_input_ack;
  logic        io_output_req, io_output_ack;
  logic [1:0]  flag_op_caddr, flag_op_daddr, flag_op_data;
  logic        flag_op_data_wr;
  logic [11:0] op_arg;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] caddr;
    logic [1:0] daddr;
    logic [1:0] dat;
    logic       wr;
    logic [11:0] arg;
  } exp_t;

  exp_t sb[$];

  bxu_front_seq dut (
    .clk             (clk),
    .rst             (rst),
    .code            (code),
    .code_valid      (code_valid),
    .code_ack        (code_ack),
    .data            (data),
    .io_input_req    (io_input_req),
    .io_input_ack    (io_input_ack),
    .io_output_req   (io_output_req),
    .io_output_ack   (io_output_ack),
    .flag_op_caddr   (flag_op_caddr),
    .flag_op_daddr   (flag_op_daddr),
    .flag_op_data    (flag_op_data),
    .flag_op_data_wr (flag_op_data_wr),
    .op_arg          (op_arg),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] arg, input logic [3:0] op);
    code       = {arg, op};
    code_valid = 1'b1;
  endtask

  task automatic expect_flags(input int c, input logic [1:0] ca, input logic [1:0] da,
                              input logic [1:0] dt, input logic wr, input logic [11:0] arg);
    exp_t e;
    e.cyc = c; e.caddr = ca; e.daddr = da; e.dat = dt; e.wr = wr; e.arg = arg;
    sb.push_back(e);
  endtask

  // Per-cycle monitor: a queued entry for this cycle is compared, otherwise flags must be idle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("caddr",   32'(flag_op_caddr),   32'(e.caddr));
      check("daddr",   32'(flag_op_daddr),   32'(e.daddr));
      check("data_op", 32'(flag_op_data),    32'(e.dat));
      check("data_wr", 32'(flag_op_data_wr), 32'(e.wr));
      check("op_arg",  32'(op_arg),          32'(e.arg));
    end else begin
      check("idle_flags", 32'({flag_op_caddr, flag_op_daddr, flag_op_data, flag_op_data_wr}), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; code = '0; code_valid = 1'b0; data = 8'h07;
    io_input_ack = 1'b0; io_output_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ireq", 32'(io_input_req), 0);
    check("rst_oreq", 32'(io_output_req), 0);
    check("rst_arg",  32'(op_arg), 0);
    tick();
    rst = 1'b0;
    tick();

    // 1: nop, d_mod R=1, s_set back to back
    issue(12'h123, OPC_NOP);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h123);
    @(negedge clk); check("t1_ack0", 32'(code_ack), 1);
    tick();
    issue(12'h001, OPC_D_MOD);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_MOD, 1'b1, 12'h001);
    @(negedge clk); check("t1_ack1", 32'(code_ack), 1);
    tick();
    issue(12'h0A5, OPC_S_SET);
    expect_flags(cyc + 1, CADDR_INC, DADDR_SET, DATA_NOP, 1'b0, 12'h0A5);
    @(negedge clk); check("t1_ack2", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    tick();

    // 2: d_mod R=5, a nop waits behind it
    issue(12'h305, OPC_D_MOD);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_MOD, 1'b1, 12'h305);
    for (int k = 2; k <= 5; k++)
      expect_flags(cyc + k, CADDR_NOP, DADDR_NOP, DATA_MOD, 1'b1, 12'h305);
    @(negedge clk); check("t2_ack", 32'(code_ack), 1);
    tick();
    issue(12'h000, OPC_NOP);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t2_busy", 32'(busy), 1);
      check("t2_noack", 32'(code_ack), 0);
      tick();
    end
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h000);
    @(negedge clk);
    check("t2_idle", 32'(busy), 0);
    check("t2_ack_after", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    tick();

    // 3: d_mod R=1 then jc_z; the cell turns 0 once the write lands
    data = 8'h07;
    issue(12'h001, OPC_D_MOD);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_MOD, 1'b1, 12'h001);
    tick();
    issue(12'h040, OPC_JC_Z);
    @(negedge clk); check("t3_hazard", 32'(code_ack), 0);
    tick();
    data = 8'h00;
    expect_flags(cyc + 1, CADDR_MOD, DADDR_NOP, DATA_NOP, 1'b0, 12'h040);
    @(negedge clk); check("t3_jc_ack", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    tick();

    // 4: input with ack delayed 3 cycles; an ack during the accept cycle is ignored
    issue(12'h0C0, OPC_IN);
    io_input_ack = 1'b1;
    @(negedge clk); check("t4_ack", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    io_input_ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        io_input_ack = 1'b1;
        expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_GET, 1'b1, 12'h0C0);
      end
      @(negedge clk);
      check("t4_req", 32'(io_input_req), 1);
      check("t4_busy", 32'(busy), 1);
      tick();
    end
    io_input_ack = 1'b0;

    // 5: output blocked one cycle by the GET write, then reset while waiting
    issue(12'h0D0, OPC_OUT);
    @(negedge clk);
    check("t4_req_drop", 32'(io_input_req), 0);
    check("t5_hazard", 32'(code_ack), 0);
    tick();
    @(negedge clk); check("t5_ack", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    @(negedge clk); check("t5_oreq", 32'(io_output_req), 1);
    tick();
    rst = 1'b1;
    #1;
    check("t5_oreq_rst", 32'(io_output_req), 0);
    check("t5_busy_rst", 32'(busy), 0);
    tick();
    rst = 1'b0;
    io_output_ack = 1'b1;
    @(negedge clk); check("t5_oreq_stays", 32'(io_output_req), 0);
    tick();
    io_output_ack = 1'b0;
    issue(12'h000, OPC_NOP);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h000);
    @(negedge clk); check("t5_post_rst_ack", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    tick();

    // 6: rep 0, illegal op, set ignores repeat, jumps, s_mod R=2
    data = 8'h05;
    issue(12'h700, OPC_D_MOD);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_MOD, 1'b1, 12'h700);
    tick();
    check("t6_rep0_busy", 32'(busy), 0);
    issue(12'h0AB, 4'b0111);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h0AB);
    @(negedge clk); check("t6_illegal_ack", 32'(code_ack), 1);
    tick();
    issue(12'h005, OPC_D_SET);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_SET, 1'b1, 12'h005);
    tick();
    check("t6_set_busy", 32'(busy), 0);
    issue(12'h123, OPC_J_SET);
    expect_flags(cyc + 1, CADDR_SET, DADDR_NOP, DATA_NOP, 1'b0, 12'h123);
    tick();
    issue(12'h0F0, OPC_JC_NZ);
    expect_flags(cyc + 1, CADDR_MOD, DADDR_NOP, DATA_NOP, 1'b0, 12'h0F0);
    @(negedge clk); check("t6_jcnz_ack", 32'(code_ack), 1);
    tick();
    issue(12'h0F1, OPC_JC_Z);
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h0F1);
    tick();
    issue(12'h002, OPC_S_MOD);
    expect_flags(cyc + 1, CADDR_INC, DADDR_MOD, DATA_NOP, 1'b0, 12'h002);
    expect_flags(cyc + 2, CADDR_NOP, DADDR_MOD, DATA_NOP, 1'b0, 12'h002);
    tick();
    issue(12'h000, OPC_NOP);
    @(negedge clk);
    check("t6_s_busy", 32'(busy), 1);
    check("t6_s_noack", 32'(code_ack), 0);
    tick();
    expect_flags(cyc + 1, CADDR_INC, DADDR_NOP, DATA_NOP, 1'b0, 12'h000);
    @(negedge clk); check("t6_s_done_ack", 32'(code_ack), 1);
    tick();
    code_valid = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
